// File: rtl/tile_map_ctrl_if.sv
// Tile map access bus: renderer read port and game-logic read/write port.
// master = requesters (renderer, game logic); slave = tile_map_ctrl.
interface tile_map_ctrl_if;
  logic       vid_req;
  logic [8:0] vid_addr;
  logic [2:0] vid_data;
  logic       vid_valid;
  logic       gm_req;
  logic       gm_we;
  logic [8:0] gm_addr;
  logic [2:0] gm_wdata;
  logic       gm_gnt;
  logic [2:0] gm_rdata;
  logic       gm_rvalid;

  modport master (
    output vid_req, vid_addr,
    input  vid_data, vid_valid,
    output gm_req, gm_we, gm_addr, gm_wdata,
    input  gm_gnt, gm_rdata, gm_rvalid
  );

  modport slave (
    input  vid_req, vid_addr,
    output vid_data, vid_valid,
    input  gm_req, gm_we, gm_addr, gm_wdata,
    output gm_gnt, gm_rdata, gm_rvalid
  );
endinterface

// File: rtl/tile_map_ctrl.sv
// Tile map RAM: ROM bulk load, then arbitrated renderer/game access.
// Ports: clk, rst_n, load_start/busy/load_done, rom_addr/rom_q, addr_err, bus.
module tile_map_ctrl #(
  parameter int MAP_DEPTH  = 300,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  output logic       busy,
  output logic       load_done,
  output logic [8:0] rom_addr,
  input  logic [2:0] rom_q,
  output logic       addr_err,
  tile_map_ctrl_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [8:0] LAST = 9'(MAP_DEPTH - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [8:0]    cnt;
  logic [SW-1:0] starve;
  logic [2:0]    ram [MAP_DEPTH];

  logic gnt_gm;
  logic gnt_vid;
  logic vid_ok;
  logic gm_ok;
  logic starved;

  assign vid_ok  = 32'(bus.vid_addr) < MAP_DEPTH;
  assign gm_ok   = 32'(bus.gm_addr) < MAP_DEPTH;
  assign starved = starve == SMAX;

  assign bus.gm_gnt = gnt_gm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    load_done = 1'b0;
    rom_addr  = '0;
    gnt_gm    = 1'b0;
    gnt_vid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        rom_addr = cnt;
        if (cnt == LAST) begin
          load_done = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        // video wins unless the game port has waited its limit
        gnt_gm  = bus.gm_req && (!bus.vid_req || starved);
        gnt_vid = bus.vid_req && !gnt_gm;
        if (load_start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      starve        <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_data  <= '0;
      bus.gm_rvalid <= 1'b0;
      bus.gm_rdata  <= '0;
      addr_err      <= 1'b0;
    end else begin
      if (state == LOAD && cnt != LAST) cnt <= cnt + 9'd1;
      else                              cnt <= '0;

      if (state == RUN && bus.gm_req && !gnt_gm)
        starve <= starved ? starve : starve + 1'b1;
      else
        starve <= '0;

      bus.vid_valid <= gnt_vid;
      bus.vid_data  <= (gnt_vid && vid_ok) ? ram[bus.vid_addr] : '0;

      bus.gm_rvalid <= gnt_gm && !bus.gm_we;
      bus.gm_rdata  <= (gnt_gm && !bus.gm_we && gm_ok)
                       ? ram[bus.gm_addr] : '0;

      addr_err <= (gnt_vid && !vid_ok) || (gnt_gm && !gm_ok);
    end
  end

  // tile storage is not reset; contents come from the ROM load
  always_ff @(posedge clk) begin
    if (state == LOAD)
      ram[cnt] <= rom_q;
    else if (gnt_gm && bus.gm_we && gm_ok)
      ram[bus.gm_addr] <= bus.gm_wdata;
  end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Randomized bench for tile_map_ctrl against a tile-array reference model.
// Ports: none; drives the DUT and a tile_map_ctrl_if instance.
module tb_tile_map_ctrl;
  localparam int DEPTH = 300;
  localparam int SMAX  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       busy;
  logic       load_done;
  logic [8:0] rom_addr;
  logic [2:0] rom_q;
  logic       addr_err;

  tile_map_ctrl_if bus();

  tile_map_ctrl #(
    .MAP_DEPTH (DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .busy      (busy),
    .load_done (load_done),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .addr_err  (addr_err),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int rom_sel = 0;
  int mem [DEPTH];
  bit run_m = 0;
  int starve_m = 0;

  function automatic int rom_fn(int sel, int a);
    if (sel == 0) begin
      if (a == 0)     return 0;
      if (a % 2 == 1) return 6;
      return (a / 2) % 7;
    end
    return (a * 3 + 1) % 8;
  endfunction

  always_comb rom_q = 3'(rom_fn(rom_sel, int'(rom_addr)));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input bit vr, input int va, input bit gr,
                       input bit gw, input int ga, input int gd,
                       output bit g);
    bit v;
    int e_vd, e_rd;
    bit e_rv, e_err;
    bus.vid_req  = vr;
    bus.vid_addr = 9'(va);
    bus.gm_req   = gr;
    bus.gm_we    = gw;
    bus.gm_addr  = 9'(ga);
    bus.gm_wdata = 3'(gd);
    #1;
    g = run_m && gr && (!vr || starve_m == SMAX);
    v = run_m && vr && !g;
    chk("gm_gnt", 32'(bus.gm_gnt), 32'(g));
    chk("busy_run", 32'(busy), 0);
    chk("rom_addr_run", 32'(rom_addr), 0);
    e_vd  = (v && va < DEPTH) ? mem[va] : 0;
    e_rv  = g && !gw;
    e_rd  = (e_rv && ga < DEPTH) ? mem[ga] : 0;
    e_err = (v && va >= DEPTH) || (g && ga >= DEPTH);
    if (g && gw && ga < DEPTH) mem[ga] = gd;
    if (run_m && gr && !g)
      starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
    else
      starve_m = 0;
    @(posedge clk);
    #1;
    chk("vid_valid", 32'(bus.vid_valid), 32'(v));
    if (v) chk("vid_data", 32'(bus.vid_data), e_vd);
    chk("gm_rvalid", 32'(bus.gm_rvalid), 32'(e_rv));
    if (e_rv) chk("gm_rdata", 32'(bus.gm_rdata), e_rd);
    chk("addr_err", 32'(addr_err), 32'(e_err));
    chk("load_done_run", 32'(load_done), 0);
  endtask

  task automatic do_load(input int sel, input bit poke);
    bus.vid_req = 1'b0;
    bus.gm_req  = 1'b0;
    rom_sel     = sel;
    load_start  = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      load_start = poke && (k == 100);
      chk("busy_load", 32'(busy), 1);
      chk("load_done", 32'(load_done), 32'(k == DEPTH));
      chk("rom_addr", 32'(rom_addr), k - 1);
      @(posedge clk);
      #1;
    end
    load_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = rom_fn(sel, a);
    run_m    = 1;
    starve_m = 0;
    chk("busy_end", 32'(busy), 0);
    chk("done_end", 32'(load_done), 0);
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_rom"}, 32'(rom_addr), 0);
    chk({tag, "_vv"}, 32'(bus.vid_valid), 0);
    chk({tag, "_vd"}, 32'(bus.vid_data), 0);
    chk({tag, "_gnt"}, 32'(bus.gm_gnt), 0);
    chk({tag, "_rv"}, 32'(bus.gm_rvalid), 0);
    chk({tag, "_rd"}, 32'(bus.gm_rdata), 0);
    chk({tag, "_err"}, 32'(addr_err), 0);
  endtask

  task automatic rand_run(input int n);
    bit g;
    for (int i = 0; i < n; i++) begin
      apply(($urandom_range(0, 9) < 6), $urandom_range(0, DEPTH + 20),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
            $urandom_range(0, DEPTH + 20), $urandom_range(0, 7), g);
    end
  endtask

  initial begin
    bit g;
    bit gs [5];
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.gm_req   = 1'b0;
    bus.gm_we    = 1'b0;
    bus.gm_addr  = '0;
    bus.gm_wdata = '0;
    #12;
    chk_outs_zero("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // idle: requests dropped
    apply(1, 5, 1, 0, 6, 0, g);
    apply(0, 0, 1, 1, 7, 3, g);

    do_load(0, 1);

    apply(1, 1, 0, 0, 0, 0, g);
    chk("ram1", 32'(bus.vid_data), 6);
    apply(1, 0, 0, 0, 0, 0, g);
    chk("ram0", 32'(bus.vid_data), 0);
    apply(1, 299, 0, 0, 0, 0, g);
    chk("ram299", 32'(bus.vid_data), 6);
    apply(1, 17, 0, 0, 0, 0, g);
    chk("vid17_v", 32'(bus.vid_valid), 1);
    chk("vid17_d", 32'(bus.vid_data), 6);

    apply(0, 0, 1, 1, 1, 0, g);
    apply(0, 0, 1, 0, 1, 0, g);
    chk("raw_v", 32'(bus.gm_rvalid), 1);
    chk("raw_d", 32'(bus.gm_rdata), 0);

    apply(0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 5; i++) begin
      apply(1, 20 + i, 1, 0, 3, 0, gs[i]);
      chk("starve_gnt", 32'(gs[i]), 32'(i == 4));
    end
    chk("starve_vv", 32'(bus.vid_valid), 0);

    apply(0, 0, 1, 0, 300, 0, g);
    chk("oor_rd", 32'(bus.gm_rdata), 0);
    chk("oor_rv", 32'(bus.gm_rvalid), 1);
    chk("oor_err", 32'(addr_err), 1);
    apply(0, 0, 1, 1, 305, 7, g);
    apply(0, 0, 0, 0, 0, 0, g);
    chk("oor_err_clr", 32'(addr_err), 0);
    apply(1, 49, 0, 0, 0, 0, g);
    apply(1, 299, 0, 0, 0, 0, g);

    rand_run(1500);
    do_load(1, 0);
    rand_run(800);

    // reset during load at cycle 150
    bus.vid_req = 1'b0;
    bus.gm_req  = 1'b0;
    rom_sel     = 0;
    load_start  = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    for (int k = 1; k < 150; k++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", 32'(busy), 1);
    chk("mid_rom", 32'(rom_addr), 149);
    bus.vid_req = 1'b1;
    bus.gm_req  = 1'b1;
    rst_n       = 1'b0;
    #1;
    chk_outs_zero("abort");
    @(posedge clk);
    #1;
    chk_outs_zero("abort_hold");
    rst_n = 1'b0;
    #2;
    rst_n    = 1'b1;
    run_m    = 0;
    starve_m = 0;
    for (int i = 0; i < 4; i++) begin
      apply(1, 10, 1, 0, 11, 0, g);
    end

    do_load(1, 0);
    rand_run(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/tile_map_ctrl.md
TILE_MAP_CTRL -- requirements
Module: tile_map_ctrl

Interface
REQ-001 SHALL have parameter MAP_DEPTH, default 300, meaning number of tiles in the 20x15 map.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles the game port may be denied.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port load_start, input, 1 bit, a pulse that requests a map (re)load from the background ROM.
REQ-006 SHALL have port busy, output, 1 bit, high while a load is in progress.
REQ-007 SHALL have port load_done, output, 1 bit, a one-cycle pulse when a load completes.
REQ-008 SHALL have port rom_addr, output, 9 bits, address to the combinational background ROM.
REQ-009 SHALL have port rom_q, input, 3 bits, ROM tile code, valid in the same cycle as rom_addr.
REQ-010 SHALL have port vid_req, input, 1 bit, renderer read request.
REQ-011 SHALL have port vid_addr, input, 9 bits, renderer tile index.
REQ-012 SHALL have port vid_data, output, 3 bits, renderer read data.
REQ-013 SHALL have port vid_valid, output, 1 bit, qualifies vid_data.
REQ-014 SHALL have port gm_req, input, 1 bit, game-logic access request.
REQ-015 SHALL have port gm_we, input, 1 bit, game-logic write enable; 0 means read.
REQ-016 SHALL have port gm_addr, input, 9 bits, game-logic tile index.
REQ-017 SHALL have port gm_wdata, input, 3 bits, game-logic write data.
REQ-018 SHALL have port gm_gnt, output, 1 bit, a combinational grant in the request cycle.
REQ-019 SHALL have port gm_rdata, output, 3 bits, game-logic read data.
REQ-020 SHALL have port gm_rvalid, output, 1 bit, qualifies gm_rdata.
REQ-021 SHALL have port addr_err, output, 1 bit, a one-cycle pulse flagging an out-of-range access.

Function
REQ-022 SHALL hold a MAP_DEPTH x 3-bit tile RAM internally.
REQ-023 SHALL implement the FSM states IDLE, LOAD and RUN; reset enters IDLE.
REQ-024 SHALL make the transition IDLE->LOAD, and RUN->LOAD, on load_start; load_start during LOAD SHALL be ignored.
REQ-025 SHALL, in LOAD, have counter cnt start at 0; each cycle rom_addr=cnt and ram[cnt]<=rom_q, with cnt incrementing; when cnt=MAP_DEPTH-1 is written, the FSM SHALL go to RUN, pulse load_done for one cycle and clear cnt; a load SHALL take exactly MAP_DEPTH cycles.
REQ-026 SHALL assert busy exactly in LOAD; rom_addr SHALL be 0 outside LOAD.
REQ-027 SHALL, in IDLE and LOAD, leave gm_gnt, vid_valid and gm_rvalid at 0; requests are dropped, not queued.
REQ-028 SHALL, in RUN, let vid_req win by default; gm_gnt = gm_req AND (NOT vid_req OR starve_cnt=STARVE_MAX).
REQ-029 SHALL track starve_cnt: +1 each RUN cycle with gm_req high and gm_gnt low, saturating at STARVE_MAX, cleared on grant or when gm_req is low.
REQ-030 SHALL, when the game wins over a simultaneous vid_req, drop that video request (vid_valid=0 next cycle).
REQ-031 SHALL serve a granted video read with 1-cycle latency: vid_valid high on the next cycle and vid_data equal to the RAM content at grant time.
REQ-032 SHALL serve a granted game read with 1-cycle latency via gm_rvalid/gm_rdata; a granted game write SHALL update the RAM at that edge and produce no gm_rvalid.
REQ-033 SHALL treat any address >= MAP_DEPTH as out of range: the access is still granted per arbitration, reads return 0 with their valid flag, writes are ignored, and addr_err pulses in the next cycle.
REQ-034 SHALL not bypass a read-after-write to the same address; the read in the cycle after the write sees the new value.

Reset
REQ-035 SHALL, on rst_n low, immediately set FSM=IDLE, cnt=0, starve_cnt=0, and all outputs (busy, load_done, rom_addr, vid_data, vid_valid, gm_gnt, gm_rdata, gm_rvalid, addr_err) to 0; RAM contents are not reset.
REQ-036 SHALL, when reset asserts mid-LOAD, abort the load; a new load_start is required afterwards.

Verification
REQ-037 SHALL be verified with: reset, then load_start pulse -> busy high for 300 cycles, load_done on cycle 300, RAM[1]=6, RAM[0]=0, RAM[299]=6.
REQ-038 SHALL be verified with: in RUN, vid_req addr 17 -> next cycle vid_valid=1, vid_data=6.
REQ-039 SHALL be verified with: gm write addr 1 data 0, then gm read addr 1 -> gm_rvalid=1, gm_rdata=0 on the following cycle.
REQ-040 SHALL be verified with: vid_req and gm_req held high -> gm_gnt=0 for 4 cycles, =1 on the 5th, and vid_valid=0 on the cycle after it.
REQ-041 SHALL be verified with: gm read addr 300 -> gm_rdata=0, gm_rvalid=1, addr_err=1 for one cycle; a write to 305 leaves the RAM unchanged.
REQ-042 SHALL be verified with: rst_n low at LOAD cycle 150 -> all outputs 0 at once, state IDLE, no load_done.
